// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction width, NOP encoding, fetch FSM states
// and the {instr, next_instr} pair carried from fetch into IF/ID.
package pipe_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDrain,
      StHeld
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] next_instr;
   } fetch_word_t;

   localparam fetch_word_t BUBBLE_WORD = '{instr: NOP_INSTR, next_instr: '0};

   function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
      return {addr[INSTR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_skid.sv
// One-entry skid buffer parking a fetched {instr, next_instr} pair while IF/ID stalls.
// Clear wins over load, load wins over unload.
module if_skid
   import pipe_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        unload_i,
   input  logic        clear_i,
   input  fetch_word_t din_i,
   output logic        valid_o,
   output fetch_word_t dout_o
);

   logic        valid_d, valid_q;
   fetch_word_t word_d, word_q;

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      if (clear_i) begin
         valid_d = 1'b0;
         word_d  = BUBBLE_WORD;
      end else if (load_i) begin
         valid_d = 1'b1;
         word_d  = din_i;
      end else if (unload_i) begin
         valid_d = 1'b0;
         word_d  = BUBBLE_WORD;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         word_q  <= BUBBLE_WORD;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

   assign valid_o = valid_q;
   assign dout_o  = word_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, stall skid and the registered
// {instr, next_instr} pair handed to IF/ID (NOP bubble whenever nothing was fetched).
module if_fetch
   import pipe_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pchold,
   input  logic               redirect,
   input  logic [INSTR_W-1:0] redirect_addr,
   output logic               imem_req,
   output logic [INSTR_W-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [INSTR_W-1:0] next_instr,
   output logic               fetch_valid
);

   fetch_state_e       state_d, state_q;
   logic [INSTR_W-1:0] pc_d, pc_q;
   logic [INSTR_W-1:0] drain_addr_d, drain_addr_q;
   fetch_word_t        out_d, out_q;
   logic               valid_d, valid_q;

   logic               skid_load, skid_unload, skid_clear, skid_valid;
   fetch_word_t        skid_din, skid_dout;
   logic [INSTR_W-1:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;
   assign skid_din = '{instr: imem_rdata, next_instr: pc_plus4};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      out_d        = out_q;
      valid_d      = valid_q;
      skid_load    = 1'b0;
      skid_unload  = 1'b0;
      skid_clear   = 1'b0;
      imem_req     = 1'b0;
      imem_addr    = pc_q;

      unique case (state_q)
         StIdle: begin
            if (!pchold) begin
               state_d = StWait;
               out_d   = BUBBLE_WORD;
               valid_d = 1'b0;
            end
         end
         StWait: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               pc_d = pc_plus4;
               if (pchold) begin
                  skid_load = 1'b1;
                  state_d   = StHeld;
               end else begin
                  out_d   = skid_din;
                  valid_d = 1'b1;
               end
            end else if (!pchold) begin
               out_d   = BUBBLE_WORD;
               valid_d = 1'b0;
            end
         end
         StDrain: begin
            // Keep presenting the flushed request until memory completes it.
            imem_req  = 1'b1;
            imem_addr = drain_addr_q;
            out_d     = BUBBLE_WORD;
            valid_d   = 1'b0;
            if (imem_ack) begin
               state_d = pchold ? StIdle : StWait;
            end
         end
         StHeld: begin
            if (!pchold) begin
               out_d       = skid_dout;
               valid_d     = skid_valid;
               skid_unload = 1'b1;
               state_d     = StWait;
            end
         end
         default: state_d = StIdle;
      endcase

      // Redirect overrides everything decided above.
      if (redirect) begin
         out_d       = BUBBLE_WORD;
         valid_d     = 1'b0;
         skid_load   = 1'b0;
         skid_unload = 1'b0;
         skid_clear  = 1'b1;
         pc_d        = word_align(redirect_addr);
         if (state_q == StWait && !imem_ack) begin
            state_d      = StDrain;
            drain_addr_d = pc_q;
         end else if (state_q == StDrain && !imem_ack) begin
            state_d = StDrain;
         end else begin
            state_d = pchold ? StIdle : StWait;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         out_q        <= BUBBLE_WORD;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         out_q        <= out_d;
         valid_q      <= valid_d;
      end
   end

   if_skid u_skid (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (skid_clear),
      .din_i    (skid_din),
      .valid_o  (skid_valid),
      .dout_o   (skid_dout)
   );

   assign instr       = out_q.instr;
   assign next_instr  = out_q.next_instr;
   assign fetch_valid = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus random stall/redirect/latency traffic,
// checked every cycle against a queue-based model of the fetched instruction stream.
module tb_if_fetch;

   localparam logic [31:0] PAT = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pchold;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] next_instr;
   logic        fetch_valid;

   logic        req_w;
   logic [31:0] addr_w;
   logic [31:0] instr_w;
   logic [31:0] next_w;
   logic        valid_w;

   always #5 clk = ~clk;

   if_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .pchold        (pchold),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .next_instr    (next_instr),
      .fetch_valid   (fetch_valid)
   );

   // Second instance starting just below the wrap point, ack tied to req.
   if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk           (clk),
      .rst           (rst),
      .pchold        (1'b0),
      .redirect      (1'b0),
      .redirect_addr (32'h0),
      .imem_req      (req_w),
      .imem_addr     (addr_w),
      .imem_ack      (req_w),
      .imem_rdata    (addr_w ^ PAT),
      .instr         (instr_w),
      .next_instr    (next_w),
      .fetch_valid   (valid_w)
   );

   int total = 0;
   int bad   = 0;

   // Memory model: ack after 'lat' extra cycles of an outstanding request.
   int lat_mode = 0;
   int lat      = 0;
   int cnt      = 0;
   bit force_ack = 1'b0;

   // Reference model: expected PC, flushed-request flag and queue of fetched words.
   logic [31:0] m_pc = 32'h0;
   bit          m_stale = 1'b0;
   logic [63:0] m_q[$];
   logic [31:0] e_instr = 32'h0;
   logic [31:0] e_next = 32'h0;
   logic [31:0] e_valid = 32'h0;

   function automatic int pick_lat();
      if (lat_mode < 0) return int'($urandom_range(0, 3));
      return lat_mode;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic        c_req, c_ack, c_ph, c_rd, c_rst;
      logic [31:0] c_addr, c_rdata, c_raddr;
      @(negedge clk);
      imem_ack   = force_ack || (imem_req && (cnt >= lat));
      imem_rdata = imem_addr ^ PAT;
      c_req   = imem_req;
      c_ack   = imem_ack;
      c_ph    = pchold;
      c_rd    = redirect;
      c_rst   = rst;
      c_addr  = imem_addr;
      c_rdata = imem_rdata;
      c_raddr = redirect_addr;
      @(posedge clk);
      #1;
      if (c_rst) begin
         cnt     = 0;
         lat     = pick_lat();
         m_pc    = 32'h0;
         m_stale = 1'b0;
         m_q.delete();
         e_instr = 32'h0;
         e_next  = 32'h0;
         e_valid = 32'h0;
         chk("rst_valid", 32'(fetch_valid), 32'h0);
         chk("rst_req", 32'(imem_req), 32'h0);
      end else begin
         if (c_req && c_ack) begin
            cnt = 0;
            lat = pick_lat();
         end else if (c_req) begin
            cnt++;
         end
         if (c_req && c_ack) begin
            if (!m_stale && !c_rd) begin
               m_q.push_back({c_rdata, c_addr + 32'd4});
               m_pc = c_addr + 32'd4;
            end
            m_stale = 1'b0;
         end else if (c_rd && c_req) begin
            m_stale = 1'b1;
         end
         if (c_rd) begin
            m_pc = {c_raddr[31:2], 2'b00};
            m_q.delete();
            e_instr = 32'h0;
            e_next  = 32'h0;
            e_valid = 32'h0;
         end else if (!c_ph) begin
            if (m_q.size() > 0) begin
               {e_instr, e_next} = m_q.pop_front();
               e_valid = 32'h1;
            end else begin
               e_instr = 32'h0;
               e_next  = 32'h0;
               e_valid = 32'h0;
            end
         end
         chk("instr", instr, e_instr);
         chk("next_instr", next_instr, e_next);
         chk("fetch_valid", 32'(fetch_valid), e_valid);
         if (!c_ph) chk("req_after_run", 32'(imem_req), 32'h1);
         if (c_req && !c_ack) begin
            chk("req_kept", 32'(imem_req), 32'h1);
            chk("addr_stable", imem_addr, c_addr);
         end
         if (m_q.size() > 0) chk("req_while_parked", 32'(imem_req), 32'h0);
         if (imem_req && !m_stale) chk("fetch_addr", imem_addr, m_pc);
      end
   endtask

   initial begin
      int          nvalid;
      bit          found;
      logic [31:0] a0;
      logic [31:0] held;

      rst           = 1'b1;
      pchold        = 1'b0;
      redirect      = 1'b0;
      redirect_addr = 32'h0;
      imem_ack      = 1'b0;
      imem_rdata    = 32'h0;
      #1;
      chk("reset_instr", instr, 32'h0);
      chk("reset_next", next_instr, 32'h0);
      chk("reset_valid", 32'(fetch_valid), 32'h0);
      chk("reset_req", 32'(imem_req), 32'h0);
      step();
      step();
      rst = 1'b0;

      // Single-cycle memory: one instruction per cycle, wrap instance crosses zero.
      lat_mode = 0;
      lat      = 0;
      step();
      chk("t1_first_addr", imem_addr, 32'h0);
      step();
      chk("wrap_instr", instr_w, 32'hFFFF_FFFC ^ PAT);
      chk("wrap_next", next_w, 32'h0);
      chk("wrap_addr", addr_w, 32'h0);
      chk("t1_instr0", instr, 32'h0 ^ PAT);
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("t1_instr", instr, (32'(i) * 32'd4) ^ PAT);
         chk("t1_next", next_instr, 32'(i) * 32'd4 + 32'd4);
         chk("t1_addr", imem_addr, 32'(i + 1) * 32'd4);
      end

      // Three-cycle latency: two bubbles between valid instructions.
      lat_mode = 2;
      lat      = 2;
      nvalid   = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (fetch_valid) nvalid++;
      end
      chk("t2_valid_count", 32'(nvalid), 32'd4);

      // Stall while ack arrives: word parks in skid, outputs freeze.
      lat_mode = 0;
      lat      = 0;
      step();
      a0     = imem_addr;
      held   = instr;
      pchold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t3_frozen", instr, held);
         chk("t3_req_low", 32'(imem_req), 32'h0);
      end
      pchold = 1'b0;
      step();
      chk("t3_parked_word", instr, a0 ^ PAT);
      chk("t3_resume_addr", imem_addr, a0 + 32'd4);

      // Redirect while a slow request is outstanding.
      lat_mode      = 2;
      lat           = 2;
      redirect      = 1'b1;
      redirect_addr = 32'h0000_0103;
      step();
      redirect = 1'b0;
      chk("t4_bubble", 32'(fetch_valid), 32'h0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (imem_req && imem_addr == 32'h0000_0100) found = 1'b1;
      end
      chk("t4_target_req", 32'(found), 32'h1);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (fetch_valid) found = 1'b1;
      end
      chk("t4_target_word", instr, 32'h0000_0100 ^ PAT);

      // Redirect coinciding with ack: acked word is dropped.
      lat_mode      = 0;
      lat           = 0;
      redirect      = 1'b1;
      redirect_addr = 32'h0000_2000;
      step();
      redirect = 1'b0;
      chk("t5_no_word", 32'(fetch_valid), 32'h0);
      chk("t5_target", imem_addr, 32'h0000_2000);
      step();
      chk("t5_first", instr, 32'h0000_2000 ^ PAT);

      // Redirect during a stall: skid flushed, idle until release.
      pchold = 1'b1;
      step();
      redirect      = 1'b1;
      redirect_addr = 32'h0000_3002;
      step();
      redirect = 1'b0;
      chk("t5_hold_bubble", 32'(fetch_valid), 32'h0);
      step();
      chk("t5_hold_idle", 32'(imem_req), 32'h0);
      pchold = 1'b0;
      step();
      chk("t5_release_valid", 32'(fetch_valid), 32'h0);
      chk("t5_release_addr", imem_addr, 32'h0000_3000);
      step();
      chk("t5_release_word", instr, 32'h0000_3000 ^ PAT);

      // Random stalls, redirects and latencies.
      lat_mode = -1;
      for (int i = 0; i < 400; i++) begin
         pchold        = ($urandom_range(0, 3) == 0);
         redirect      = ($urandom_range(0, 11) == 0);
         redirect_addr = $urandom;
         step();
      end
      pchold   = 1'b0;
      redirect = 1'b0;

      // Reset mid-request, then a late ack that must be ignored.
      lat_mode = 3;
      lat      = 3;
      cnt      = 0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("t6_rst_instr", instr, 32'h0);
      chk("t6_rst_next", next_instr, 32'h0);
      chk("t6_rst_valid", 32'(fetch_valid), 32'h0);
      chk("t6_rst_req", 32'(imem_req), 32'h0);
      force_ack = 1'b1;
      step();
      rst = 1'b0;
      step();
      force_ack = 1'b0;
      chk("t6_late_ack_valid", 32'(fetch_valid), 32'h0);
      chk("t6_restart_addr", imem_addr, 32'h0);
      lat_mode = 0;
      lat      = 0;
      step();
      chk("t6_first_word", instr, 32'h0 ^ PAT);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
